// File: rtl/btn_cond.sv
`timescale 1ns/1ps
// btn_cond -- push-button conditioner for the 24-hour clock front panel.
//
// Each raw button passes through a 2-FF synchronizer and then a sample-based
// debouncer. A debounced rising edge becomes a single-CLK pulse on MODE,
// SELECT or ADJUST. When several events fall in the same cycle, MODE wins
// over SELECT, and SELECT wins over ADJUST. The losing events are dropped.
//
// Optional feature, selected by the macro BTN_COND_AUTOREPEAT_EN:
//   When it is defined, ADJUST auto-repeats while the button is held. The
//   first repeat comes RPT_DLY samples after the press pulse, and further
//   repeats come every RPT_PER samples. When it is undefined, ADJUST gives
//   one pulse per press and RPT_DLY/RPT_PER are ignored.
//
// Parameters:
//   DB_CNT   consecutive differing samples needed to accept a level (2..15)
//   RPT_DLY  samples from the press pulse to the first repeat (2..255)
//   RPT_PER  samples between repeat pulses (1..255)
// Ports:
//   CLK                              system clock
//   RST                              asynchronous active-high reset
//   SMPEN                            one-CLK sample strobe from the prescaler
//   BTN_MODE, BTN_SELECT, BTN_ADJUST raw asynchronous active-high buttons
//   MODE, SELECT, ADJUST             registered one-CLK event pulses
module btn_cond #(
  parameter int DB_CNT  = 4,
  parameter int RPT_DLY = 16,
  parameter int RPT_PER = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic SMPEN,
  input  logic BTN_MODE,
  input  logic BTN_SELECT,
  input  logic BTN_ADJUST,
  output logic MODE,
  output logic SELECT,
  output logic ADJUST
);

  localparam int            CW      = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);

  if (DB_CNT < 2 || DB_CNT > 15) begin : g_bad_db_cnt
    $error("btn_cond: DB_CNT must be within 2..15");
  end
  if (RPT_DLY < 2 || RPT_DLY > 255) begin : g_bad_rpt_dly
    $error("btn_cond: RPT_DLY must be within 2..255");
  end
  if (RPT_PER < 1 || RPT_PER > 255) begin : g_bad_rpt_per
    $error("btn_cond: RPT_PER must be within 1..255");
  end

  // Bit order in all per-button vectors: [0]=MODE, [1]=SELECT, [2]=ADJUST.
  logic [2:0] btn_raw;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [2:0] stable_p2;
  logic [2:0] stable_nxt;
  logic [2:0] press;
  logic       adj_ev;
  logic       mode_win;
  logic       sel_win;
  logic       adj_win;

  assign btn_raw = {BTN_ADJUST, BTN_SELECT, BTN_MODE};

  // ---- stage p0/p1: two-flop synchronizer ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: debounce counter and stable level ----
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          stable;
    logic          accept;

    // The DB_CNT-th consecutive differing sample is accepted on this edge.
    // The press is decoded from the next stable value and not from the
    // registered one, so the output pulse lines up with the stable update.
    assign accept        = SMPEN && (sync_p1[i] != stable) && (cnt == DB_LAST);
    assign stable_nxt[i] = accept ? sync_p1[i] : stable;
    assign press[i]      = accept && sync_p1[i];
    assign stable_p2[i]  = stable;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (SMPEN) begin
        if (sync_p1[i] == stable || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        stable <= stable_nxt[i];
      end
    end
  end

`ifdef BTN_COND_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  rpt_state_t rpt_state;
  logic [7:0] rpt_cnt;
  logic       rpt_fire;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A repeat fires on the sample where the count would reach its target.
  // If the release is accepted on the same edge, the repeat is suppressed.
  always_comb begin
    rpt_fire = 1'b0;
    if (SMPEN && stable_nxt[2]) begin
      if (rpt_state == RPT_DELAY && sat_inc8(rpt_cnt) == 8'(RPT_DLY)) begin
        rpt_fire = 1'b1;
      end
      if (rpt_state == RPT_REPEAT && sat_inc8(rpt_cnt) == 8'(RPT_PER)) begin
        rpt_fire = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else if (!stable_nxt[2]) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          // A press that loses arbitration still starts the delay timer.
          if (press[2]) begin
            rpt_state <= RPT_DELAY;
            rpt_cnt   <= '0;
          end
        end
        RPT_DELAY: begin
          if (rpt_fire) begin
            rpt_state <= RPT_REPEAT;
            rpt_cnt   <= '0;
          end else if (SMPEN) begin
            rpt_cnt <= sat_inc8(rpt_cnt);
          end
        end
        RPT_REPEAT: begin
          if (rpt_fire) begin
            rpt_cnt <= '0;
          end else if (SMPEN) begin
            rpt_cnt <= sat_inc8(rpt_cnt);
          end
        end
        default: begin
          rpt_state <= RPT_IDLE;
          rpt_cnt   <= '0;
        end
      endcase
    end
  end

  assign adj_ev = press[2] | rpt_fire;
`else
  assign adj_ev = press[2];
`endif

  // Fixed priority. A lower-priority event that loses is dropped, not queued.
  assign mode_win = press[0];
  assign sel_win  = press[1] & ~press[0];
  assign adj_win  = adj_ev & ~press[0] & ~press[1];

  // ---- output register ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MODE   <= 1'b0;
      SELECT <= 1'b0;
      ADJUST <= 1'b0;
    end else begin
      MODE   <= mode_win;
      SELECT <= sel_win;
      ADJUST <= adj_win;
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
`timescale 1ns/1ps
// tb_btn_cond -- directed self-checking bench for btn_cond.
// Setup: DB_CNT=4, RPT_DLY=16, RPT_PER=4, SMPEN every 10 CLK (or stuck high).
// The expected ADJUST schedule follows BTN_COND_AUTOREPEAT_EN.
module tb_btn_cond;

  logic CLK        = 1'b0;
  logic RST        = 1'b1;
  logic SMPEN      = 1'b0;
  logic BTN_MODE   = 1'b0;
  logic BTN_SELECT = 1'b0;
  logic BTN_ADJUST = 1'b0;
  logic MODE;
  logic SELECT;
  logic ADJUST;

  int checks   = 0;
  int failures = 0;

  int smp_div   = 0;
  bit smp_stuck = 1'b0;
  int smp_total = 0;

  int   n_mode   = 0;
  int   n_sel    = 0;
  int   n_adj    = 0;
  int   n_wide   = 0;
  int   n_multi  = 0;
  int   n_rst_hi = 0;
  logic mode_d   = 1'b0;
  logic sel_d    = 1'b0;
  logic adj_d    = 1'b0;
  int   adj_q[$];

  int exp_off[7] = '{0, 16, 20, 24, 28, 32, 36};

  btn_cond #(
    .DB_CNT (4),
    .RPT_DLY(16),
    .RPT_PER(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SMPEN     (SMPEN),
    .BTN_MODE  (BTN_MODE),
    .BTN_SELECT(BTN_SELECT),
    .BTN_ADJUST(BTN_ADJUST),
    .MODE      (MODE),
    .SELECT    (SELECT),
    .ADJUST    (ADJUST)
  );

  always #5 CLK = ~CLK;

  // Sample strobe generator. smp_total counts the edges that saw SMPEN high.
  always @(posedge CLK) begin
    if (SMPEN) smp_total++;
    #1;
    smp_div = (smp_div == 9) ? 0 : smp_div + 1;
    SMPEN   = smp_stuck || (smp_div == 0);
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (MODE)   n_mode++;
    if (SELECT) n_sel++;
    if (ADJUST) begin
      n_adj++;
      adj_q.push_back(smp_total);
    end
    if ((MODE && mode_d) || (SELECT && sel_d) || (ADJUST && adj_d)) n_wide++;
    if (int'(MODE) + int'(SELECT) + int'(ADJUST) > 1) n_multi++;
    if (RST && (MODE || SELECT || ADJUST)) n_rst_hi++;
    mode_d = MODE;
    sel_d  = SELECT;
    adj_d  = ADJUST;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_smp(input int n);
    int tgt;
    tgt = smp_total + n;
    for (int k = 0; k < 20 * n + 20 && smp_total < tgt; k++) @(negedge CLK);
  endtask

  // Call at the negedge where the button was just driven. Returns the number
  // of samples the debouncer saw before the pulse, and the total CLK count.
  // smp = -1 means no pulse arrived within the budget.
  task automatic press_latency(input int which, output int smp, output int cyc);
    bit   got;
    logic o;
    smp = 0;
    cyc = 2;
    got = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 600 && !got; k++) begin
      if (SMPEN) smp++;
      @(negedge CLK);
      cyc++;
      case (which)
        0:       o = MODE;
        1:       o = SELECT;
        default: o = ADJUST;
      endcase
      if (o) got = 1'b1;
    end
    if (!got) smp = -1;
  endtask

  initial begin
    int s, c, m0, s0, a0, base;

    // reset state
    repeat (3) @(negedge CLK);
    check_eq("rst_mode", MODE, 0);
    check_eq("rst_select", SELECT, 0);
    check_eq("rst_adjust", ADJUST, 0);
    RST = 1'b0;
    wait_clk(5);

    // clean press, held for 200 CLK, then released
    m0 = n_mode; s0 = n_sel; a0 = n_adj;
    BTN_MODE = 1'b1;
    press_latency(0, s, c);
    check_eq("mode_latency_smp", s, 4);
    wait_clk(200 - c);
    check_eq("mode_press_count", n_mode - m0, 1);
    BTN_MODE = 1'b0;
    wait_clk(100);
    check_eq("mode_release_count", n_mode - m0, 1);
    check_eq("mode_others", (n_sel - s0) + (n_adj - a0), 0);

    // a press of only 3 samples must not be accepted, and the next press
    // starts again from zero
    wait_smp(1);
    m0 = n_mode;
    BTN_MODE = 1'b1;
    wait_smp(3);
    BTN_MODE = 1'b0;
    wait_smp(3);
    check_eq("mode_short_press", n_mode - m0, 0);
    BTN_MODE = 1'b1;
    press_latency(0, s, c);
    check_eq("mode_fresh_latency", s, 4);
    BTN_MODE = 1'b0;
    wait_clk(100);

    // bounce: toggle every 7 CLK, quiet low, then settle high
    s0 = n_sel;
    for (int k = 0; k < 8; k++) begin
      BTN_SELECT = ~k[0];
      wait_clk(7);
    end
    BTN_SELECT = 1'b0;
    wait_clk(20);
    check_eq("sel_bounce_none", n_sel - s0, 0);
    BTN_SELECT = 1'b1;
    press_latency(1, s, c);
    check_eq("sel_settle_latency", s, 4);
    wait_clk(100);
    check_eq("sel_settle_count", n_sel - s0, 1);
    BTN_SELECT = 1'b0;
    wait_clk(100);

    // arbitration: MODE beats SELECT
    m0 = n_mode; s0 = n_sel;
    BTN_MODE = 1'b1;
    BTN_SELECT = 1'b1;
    press_latency(0, s, c);
    check_eq("arb_ms_latency", s, 4);
    wait_clk(100);
    check_eq("arb_ms_mode", n_mode - m0, 1);
    check_eq("arb_ms_select", n_sel - s0, 0);
    BTN_MODE = 1'b0;
    BTN_SELECT = 1'b0;
    wait_clk(100);

    // arbitration: SELECT beats ADJUST
    s0 = n_sel; a0 = n_adj;
    BTN_SELECT = 1'b1;
    BTN_ADJUST = 1'b1;
    press_latency(1, s, c);
    check_eq("arb_sa_latency", s, 4);
    wait_smp(8);
    BTN_SELECT = 1'b0;
    BTN_ADJUST = 1'b0;
    wait_clk(100);
    check_eq("arb_sa_select", n_sel - s0, 1);
    check_eq("arb_sa_adjust", n_adj - a0, 0);

    // hold ADJUST from acceptance to acceptance+34 samples
    adj_q.delete();
    BTN_ADJUST = 1'b1;
    press_latency(2, s, c);
    check_eq("adj_latency", s, 4);
    base = smp_total;
    wait_smp(34);
    BTN_ADJUST = 1'b0;
    wait_clk(150);
`ifdef BTN_COND_AUTOREPEAT_EN
    check_eq("rpt_count", adj_q.size(), 7);
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("rpt_offset%0d", k),
               (k < adj_q.size()) ? adj_q[k] - base : -1, exp_off[k]);
    end
`else
    check_eq("adj_single_count", adj_q.size(), 1);
    check_eq("adj_single_offset", (adj_q.size() > 0) ? adj_q[0] - base : -1, 0);
`endif
    a0 = n_adj;
    wait_clk(100);
    check_eq("adj_after_release", n_adj - a0, 0);

    // a second press needs a fresh debounce
    BTN_ADJUST = 1'b1;
    press_latency(2, s, c);
    check_eq("adj_repress_latency", s, 4);
    BTN_ADJUST = 1'b0;
    wait_clk(100);

    // reset while ADJUST is auto-repeating, with the button still held
    BTN_ADJUST = 1'b1;
    press_latency(2, s, c);
    wait_smp(18);
    RST = 1'b1;
    wait_clk(1);
    check_eq("rst_mid_outputs", {MODE, SELECT, ADJUST}, 0);
    wait_clk(2);
    adj_q.delete();
    RST = 1'b0;
    press_latency(2, s, c);
    check_eq("rst_relatch_latency", s, 4);
    wait_smp(17);
`ifdef BTN_COND_AUTOREPEAT_EN
    check_eq("rst_rpt_count", adj_q.size(), 2);
    check_eq("rst_rpt_delay", (adj_q.size() > 1) ? adj_q[1] - adj_q[0] : -1, 16);
`else
    check_eq("rst_single_count", adj_q.size(), 1);
`endif
    BTN_ADJUST = 1'b0;
    wait_clk(150);

    // SMPEN stuck high: debounce takes DB_CNT CLK cycles after the synchronizer
    smp_stuck = 1'b1;
    wait_clk(3);
    BTN_MODE = 1'b1;
    press_latency(0, s, c);
    check_eq("stuck_latency_smp", s, 4);
    check_eq("stuck_latency_clk", c, 6);
    BTN_MODE = 1'b0;
    wait_clk(20);
    smp_stuck = 1'b0;
    wait_clk(20);

    // properties over the whole run
    check_eq("pulse_width_1clk", n_wide, 0);
    check_eq("one_output_per_cycle", n_multi, 0);
    check_eq("quiet_during_reset", n_rst_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "tb_btn_cond timeout");
  end

endmodule

// File: doc/btn_cond.md
# btn_cond

Push-button conditioner for the 24-hour clock: synchronizes, debounces and edge-detects the three raw front-panel buttons and produces the single-CLK-cycle MODE, SELECT and ADJUST pulses consumed by the clock's mode/adjust state machine. ADJUST optionally auto-repeats while held so minutes and hours can be fast-advanced. The block sits between the board pins and the state machine, with its sample enable driven by the existing prescaler.

## Interface
- DB_CNT, 4: consecutive differing samples required to accept a new button level (2..15).
- RPT_DLY, 16: samples ADJUST must be held after acceptance before auto-repeat starts (2..255).
- RPT_PER, 4: samples between auto-repeat pulses (1..255).
- CLK  in  1  system clock. Reset RST, asynchronous, active-high; clock CLK.
- RST  in  1  asynchronous active-high reset.
- SMPEN  in  1  one-CLK sample strobe from the prescaler (nominally 100 Hz); sync to CLK.
- BTN_MODE, BTN_SELECT, BTN_ADJUST  in  1 each  raw buttons, active-high, asynchronous, bouncing.
- MODE, SELECT, ADJUST  out  1 each  registered one-CLK pulses, active-high.

## Operation
- Per button: 2-FF synchronizer, then debounce counter (width clog2(DB_CNT+1)) and stable-level register.
- On SMPEN: if synced level != stable, counter += 1; if synced level == stable, counter <= 0. When counter would reach DB_CNT, stable <= synced level and counter <= 0.
- Between SMPEN strobes the counter and stable level hold.
- Press event = stable 0->1. Release (1->0) generates nothing.
- Arbitration, same CLK cycle: MODE > SELECT > ADJUST. A lower-priority event coinciding with a higher one is dropped, not deferred. At most one output high per cycle.
- ADJUST repeat FSM (macro-enabled only): IDLE -> press: pulse, DELAY (cnt=0). DELAY: cnt += 1 per SMPEN; at cnt==RPT_DLY pulse, REPEAT (cnt=0). REPEAT: cnt += 1 per SMPEN; at cnt==RPT_PER pulse, cnt=0. Any state: stable ADJUST==0 -> IDLE, cnt=0. Repeat pulses obey the same arbitration.
- Repeat counter: 8 bits, saturates; never wraps.

## Timing
- Reset values: all outputs 0, sync FFs 0, stable levels 0, counters 0, FSM IDLE.
- Input-to-sync latency: 2 CLK.
- Stable level updates on the CLK edge that samples the DB_CNT-th consecutive differing SMPEN. The output pulse is high during the next CLK cycle, width exactly 1 CLK.
- Bounce shorter than one sample interval, or any matching sample before DB_CNT, restarts acceptance from 0.
- A button held through reset release is seen as a press: one pulse after 2 CLK + DB_CNT samples.
- RST asserted mid-count or mid-repeat: immediate return to reset values, with no pulse in the reset cycle.
- SMPEN stuck high: debounce degenerates to DB_CNT CLK cycles. This is legal and used in simulation.

## Configuration
- BTN_COND_AUTOREPEAT_EN defined: ADJUST repeat FSM is compiled in as described, and RPT_DLY/RPT_PER are used.
- Undefined: FSM and repeat counter are removed, and RPT_DLY/RPT_PER are ignored. ADJUST produces exactly one pulse per debounced press, like MODE and SELECT.

## Test plan
Common setup: DB_CNT=4, RPT_DLY=16, RPT_PER=4, SMPEN every 10 CLK.

- Clean press: BTN_MODE 0->1 held 200 CLK -> exactly one MODE pulse, 1 CLK wide, in the cycle after the 4th sample seeing 1. No pulse on release.
- Bounce: BTN_SELECT toggles every 7 CLK for 60 CLK, then settles at 1 -> one SELECT pulse, 4 samples after settling. None during the bounce.
- Arbitration: BTN_MODE and BTN_SELECT pressed in the same CLK -> one MODE pulse, zero SELECT pulses. Same test with SELECT and ADJUST -> SELECT only.
- Auto-repeat (macro defined): BTN_ADJUST held for 40 samples -> pulses at acceptance, +16, +20, +24, +28, +32, +36 samples (7 total). Release -> pulses stop; re-press -> first pulse only after a fresh debounce.
- Auto-repeat (macro undefined): same stimulus -> exactly 1 ADJUST pulse.
- Reset mid-operation: RST for 3 CLK while BTN_ADJUST is in REPEAT -> outputs 0 during reset. After release, with the button still held, one pulse after 2 CLK + 4 samples, then the repeat schedule restarts from DELAY.
